// File: rtl/seq_detect_if.sv
// Handshake/bus bundle for seq_detect_ctrl: configuration, run control,
// serial bit input and status outputs.
interface seq_detect_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [3:0]       cfg_len;
  logic [CNT_W-1:0] cfg_limit;
  logic             start;
  logic             abort;
  logic             ip_valid;
  logic             ip;
  logic             done_ack;
  logic             match;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_count;
  logic             cfg_err;

  // Driver side (controller / testbench)
  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_limit,
    output start, abort, ip_valid, ip, done_ack,
    input  match, busy, done, hit_count, cfg_err
  );

  // Detector side
  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_limit,
    input  start, abort, ip_valid, ip, done_ack,
    output match, busy, done, hit_count, cfg_err
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Serial bit-pattern detector with run control. A run is armed by start,
// counts (possibly overlapping) pattern hits and finishes either on abort
// or once a nonzero hit limit is reached, then waits for done_ack.
// Lengths are 4 bits wide, so PAT_W is expected to lie in 6..15.
module seq_detect_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         rst,
  seq_detect_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [PAT_W-1:0] RST_PATTERN = PAT_W'(6'b101101);
  localparam logic [3:0]       RST_LEN     = 4'd6;
  localparam logic [3:0]       MAX_LEN     = 4'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [3:0]       fill_q, fill_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic             match_q, match_d;
  logic             cfg_err_q, cfg_err_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [3:0]       len_q, len_d;
  logic [CNT_W-1:0] limit_q, limit_d;

  // Comparison mask selecting the low len_q bits of history and pattern
  logic [PAT_W-1:0] len_mask;
  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign len_mask[gi] = (len_q > 4'(gi));
    end
  endgenerate

  // History and fill count as they would be after accepting the current bit
  logic [PAT_W-1:0] hist_shift;
  logic [3:0]       fill_inc;
  logic             hit_now;
  logic             limit_reached;
  logic             cfg_len_ok;

  assign hist_shift    = {hist_q[PAT_W-2:0], bus.ip};
  assign fill_inc      = (fill_q == MAX_LEN) ? fill_q : fill_q + 4'd1;
  assign hit_now       = (fill_inc >= len_q) &&
                         (((hist_shift ^ pattern_q) & len_mask) == '0);
  // The hit that reaches the limit is registered first; DONE follows a cycle later
  assign limit_reached = (limit_q != '0) && (hit_count_q == limit_q);
  assign cfg_len_ok    = (bus.cfg_len != 4'd0) && (bus.cfg_len <= MAX_LEN);

  // Next-state, configuration, history and hit-count logic
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    hit_count_d = hit_count_q;
    pattern_d   = pattern_q;
    len_d       = len_q;
    limit_d     = limit_q;
    match_d     = 1'b0;
    cfg_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_we) begin
          if (cfg_len_ok) begin
            pattern_d = bus.cfg_pattern;
            len_d     = bus.cfg_len;
            limit_d   = bus.cfg_limit;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        // abort has priority over start while idle
        if (bus.start && !bus.abort) begin
          state_d     = ST_ARMED;
          hit_count_d = '0;
          hist_d      = '0;
          fill_d      = 4'd0;
        end
      end

      ST_ARMED: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (limit_reached) begin
          state_d = ST_DONE;
        end else if (bus.ip_valid) begin
          hist_d = hist_shift;
          fill_d = fill_inc;
          if (hit_now) begin
            match_d = 1'b1;
            if (limit_q != '0) begin
              hit_count_d = hit_count_q + 1'b1;
            end else if (hit_count_q != CNT_MAX) begin
              hit_count_d = hit_count_q + 1'b1;
            end
          end
        end
      end

      ST_DONE: begin
        if (bus.done_ack) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset to the default configuration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hist_q      <= '0;
      fill_q      <= 4'd0;
      hit_count_q <= '0;
      match_q     <= 1'b0;
      cfg_err_q   <= 1'b0;
      pattern_q   <= RST_PATTERN;
      len_q       <= RST_LEN;
      limit_q     <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      hit_count_q <= hit_count_d;
      match_q     <= match_d;
      cfg_err_q   <= cfg_err_d;
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      limit_q     <= limit_d;
    end
  end

  assign bus.match     = match_q;
  assign bus.busy      = (state_q == ST_ARMED);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.hit_count = hit_count_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed scenarios followed by
// randomized traffic, all checked against a queue-based behavioural model.
module tb_seq_detect_ctrl;

  logic clk;
  logic rst;

  seq_detect_if #(.PAT_W(8), .CNT_W(8)) bus ();

  seq_detect_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Behavioural model: accepted bits kept as a queue, newest at the back
  bit       m_armed;
  bit       m_done;
  bit       m_match;
  bit       m_err;
  int       m_hits;
  bit [7:0] m_pat;
  int       m_len;
  int       m_lim;
  bit       m_bits[$];

  task automatic model_reset();
    m_armed = 0;
    m_done  = 0;
    m_match = 0;
    m_err   = 0;
    m_hits  = 0;
    m_pat   = 8'b0010_1101;
    m_len   = 6;
    m_lim   = 0;
    m_bits.delete();
  endtask

  function automatic bit tail_matches();
    if (m_bits.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    m_match = 0;
    m_err   = 0;
    if (!m_armed && !m_done) begin
      if (bus.cfg_we) begin
        if (bus.cfg_len >= 1 && bus.cfg_len <= 8) begin
          m_pat = bus.cfg_pattern;
          m_len = int'(bus.cfg_len);
          m_lim = int'(bus.cfg_limit);
        end else begin
          m_err = 1;
        end
      end
      if (bus.start && !bus.abort) begin
        m_armed = 1;
        m_hits  = 0;
        m_bits.delete();
      end
    end else if (m_armed) begin
      if (bus.abort) begin
        m_armed = 0;
      end else if (m_lim != 0 && m_hits == m_lim) begin
        m_armed = 0;
        m_done  = 1;
      end else if (bus.ip_valid) begin
        m_bits.push_back(bus.ip);
        if (m_bits.size() > 8) void'(m_bits.pop_front());
        if (tail_matches()) begin
          m_match = 1;
          if (m_lim != 0 || m_hits < 255) m_hits++;
        end
      end
    end else begin
      if (bus.done_ack) m_done = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".match"},     32'(bus.match),     32'(m_match));
    check({tag, ".busy"},      32'(bus.busy),      32'(m_armed));
    check({tag, ".done"},      32'(bus.done),      32'(m_done));
    check({tag, ".cfg_err"},   32'(bus.cfg_err),   32'(m_err));
    check({tag, ".hit_count"}, 32'(bus.hit_count), 32'(m_hits));
  endtask

  task automatic clear_inputs();
    bus.cfg_we      = 0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_limit   = '0;
    bus.start       = 0;
    bus.abort       = 0;
    bus.ip_valid    = 0;
    bus.ip          = 0;
    bus.done_ack    = 0;
  endtask

  // One clock with the currently driven inputs, then check and release them
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
    $display("cycle %s: match=%0b busy=%0b done=%0b cfg_err=%0b hits=%0d",
             tag, bus.match, bus.busy, bus.done, bus.cfg_err, bus.hit_count);
    clear_inputs();
  endtask

  task automatic feed(input bit b);
    bus.ip_valid = 1;
    bus.ip       = b;
    tick("bit");
  endtask

  task automatic do_start();
    bus.start = 1;
    tick("start");
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] lim);
    bus.cfg_we      = 1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_limit   = lim;
    tick("cfg");
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic apply_reset();
    rst = 1;
    #1;
    model_reset();
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    check_outputs("rst_hold");
    rst = 0;
  endtask

  bit seq6[6];
  int nmatch;

  initial begin
    checks = 0;
    errors = 0;
    seq6   = '{1, 0, 1, 1, 0, 1};
    clear_inputs();
    model_reset();
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 0;

    // Default pattern 101101, one hit after the sixth bit, stays armed
    do_start();
    for (int i = 0; i < 6; i++) feed(seq6[i]);
    check("d038_match", 32'(bus.match), 32'd1);
    check("d038_hits",  32'(bus.hit_count), 32'd1);
    check("d038_busy",  32'(bus.busy), 32'd1);
    bus.abort = 1;
    tick("abort");

    // Pattern 1010 len 4 limit 2: overlapping hits, then DONE and ack
    do_cfg(8'b1010, 4'd4, 8'd2);
    do_start();
    feed(1); feed(0); feed(1); feed(0);
    check("d039_match1", 32'(bus.match), 32'd1);
    feed(1); feed(0);
    check("d039_match2", 32'(bus.match), 32'd1);
    check("d039_hits2",  32'(bus.hit_count), 32'd2);
    tick("wait_done");
    check("d039_done", 32'(bus.done), 32'd1);
    check("d039_busy", 32'(bus.busy), 32'd0);
    bus.done_ack = 1;
    tick("ack");
    check("d039_idle", 32'(bus.done), 32'd0);
    check("d039_hits", 32'(bus.hit_count), 32'd2);

    // Gaps of invalid cycles between bits change nothing
    do_cfg(8'b0010_1101, 4'd6, 8'd0);
    do_start();
    nmatch = 0;
    for (int i = 0; i < 6; i++) begin
      feed(seq6[i]);
      nmatch += int'(bus.match);
      bus.ip = 1'($urandom);
      tick("gap");
      nmatch += int'(bus.match);
    end
    check("d040_one_match", 32'(nmatch), 32'd1);
    bus.abort = 1;
    tick("abort");

    // Illegal lengths raise cfg_err; writes while armed are ignored
    do_cfg(8'hFF, 4'd0, 8'd1);
    check("d041_err0", 32'(bus.cfg_err), 32'd1);
    do_cfg(8'hFF, 4'd9, 8'd1);
    check("d041_err9", 32'(bus.cfg_err), 32'd1);
    do_start();
    do_cfg(8'h0F, 4'd4, 8'd1);
    check("d041_noerr", 32'(bus.cfg_err), 32'd0);
    for (int i = 0; i < 6; i++) feed(seq6[i]);
    check("d041_oldcfg", 32'(bus.match), 32'd1);
    bus.abort = 1;
    tick("abort");

    // start+abort together stays idle; abort keeps hit count; start clears it
    bus.start = 1;
    bus.abort = 1;
    tick("start_abort");
    check("d042_idle", 32'(bus.busy), 32'd0);
    do_cfg(8'b1, 4'd1, 8'd0);
    do_start();
    feed(1); feed(1); feed(1);
    bus.abort = 1;
    tick("abort");
    check("d042_hits3", 32'(bus.hit_count), 32'd3);
    check("d042_busy",  32'(bus.busy), 32'd0);
    do_start();
    check("d042_clear", 32'(bus.hit_count), 32'd0);
    bus.abort = 1;
    tick("abort");

    // Reset mid-run discards history; a lone sixth bit cannot match
    apply_reset();
    do_start();
    for (int i = 0; i < 5; i++) feed(seq6[i]);
    apply_reset();
    check("d043_busy", 32'(bus.busy), 32'd0);
    do_start();
    feed(1);
    check("d043_nomatch", 32'(bus.match), 32'd0);
    tick("idle");

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        bus.cfg_we      = 1;
        bus.cfg_pattern = 8'($urandom);
        bus.cfg_len     = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 3))
                                                     : 4'($urandom_range(0, 10));
        bus.cfg_limit   = 8'($urandom_range(0, 3));
      end
      bus.start    = ($urandom_range(0, 9) == 0);
      bus.abort    = ($urandom_range(0, 39) == 0);
      bus.ip_valid = ($urandom_range(0, 9) < 6);
      bus.ip       = 1'($urandom);
      bus.done_ack = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 499) == 0) begin
        clear_inputs();
        apply_reset();
      end else begin
        tick("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter PAT_W, default 8, maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 8, width of hit counter and hit limit.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cfg_we  input  1  config write strobe; sampled only in IDLE.
REQ-006 cfg_pattern  input  PAT_W  target pattern; bit [len-1] is the oldest bit, bit [0] is the newest.
REQ-007 cfg_len  input  4  pattern length; legal range 1..PAT_W.
REQ-008 cfg_limit  input  CNT_W  hit count that ends a run; 0 means unlimited.
REQ-009 start  input  1  single-cycle arm request.
REQ-010 abort  input  1  single-cycle run cancel.
REQ-011 ip_valid  input  1  serial bit qualifier.
REQ-012 ip  input  1  serial data bit.
REQ-013 match  output  1  one-cycle hit pulse.
REQ-014 busy  output  1  high while ARMED.
REQ-015 done  output  1  high while DONE.
REQ-016 done_ack  input  1  acknowledge for done.
REQ-017 hit_count  output  CNT_W  hits in the current or last run.
REQ-018 cfg_err  output  1  one-cycle pulse on a rejected config write.

Function
REQ-019 The FSM SHALL have three states: IDLE, ARMED, DONE.
REQ-020 IDLE -> ARMED on start with abort low; on this transition: hit_count cleared, history cleared, fill counter cleared.
REQ-021 ARMED -> IDLE on abort; hit_count is retained.
REQ-022 ARMED -> DONE in the cycle after the hit that makes hit_count equal a nonzero cfg_limit.
REQ-023 DONE -> IDLE on done_ack; done_ack in any other state is ignored.
REQ-024 start outside IDLE is ignored; abort wins over start when both are high in IDLE (state stays IDLE).
REQ-025 In ARMED, each cycle with ip_valid high shifts ip into the LSB of a PAT_W-bit history register and increments the fill counter, which saturates at PAT_W; cycles with ip_valid low leave history and fill counter unchanged.
REQ-026 A hit occurs when an ip_valid bit is accepted, the fill count including that bit is >= len, and the low len bits of the updated history equal the low len bits of the stored pattern.
REQ-027 Overlapping hits are detected; history is not cleared after a hit.
REQ-028 match is registered and asserts exactly one cycle after the clock edge that accepts the completing bit; the same edge increments hit_count.
REQ-029 When cfg_limit is 0, hit_count saturates at all ones and the FSM never enters DONE.
REQ-030 Bits are not accepted and match never asserts in IDLE or DONE.
REQ-031 A cfg_we in IDLE with cfg_len in 1..PAT_W loads pattern, len and limit at the next edge.
REQ-032 A cfg_we with cfg_len of 0 or greater than PAT_W is rejected: stored config is unchanged and cfg_err pulses for one cycle.
REQ-033 A cfg_we in ARMED or DONE is ignored without a cfg_err pulse.
REQ-034 busy and done are decoded from registered state and are never high together.

Reset
REQ-035 Asserting rst SHALL immediately set: state IDLE, match 0, busy 0, done 0, cfg_err 0, hit_count 0, history 0, fill counter 0.
REQ-036 Reset loads the stored config: pattern 6'b101101 (zero-extended), len 6, limit 0.
REQ-037 rst asserted mid-run discards the run; after rst deasserts, no match may occur until start is received and len new valid bits have been accepted.

Verification
REQ-038 Reset config; start; feed 1,0,1,1,0,1 -> one match pulse 1 cycle after the 6th bit; hit_count=1; busy stays 1.
REQ-039 Config pattern 4'b1010, len 4, limit 2; start; feed 1,0,1,0,1,0 -> matches after bits 4 and 6; done=1 on the cycle after the 2nd match; done_ack -> IDLE with hit_count=2.
REQ-040 ip_valid toggled low between bits of 101101 -> exactly one match; invalid cycles have no effect.
REQ-041 cfg_we with cfg_len=0, then with cfg_len=9 -> two cfg_err pulses and the stored config is unchanged; cfg_we during ARMED -> no change and no cfg_err.
REQ-042 start and abort high together in IDLE -> stays IDLE; abort after 3 hits -> IDLE with hit_count=3; a later start clears hit_count to 0.
REQ-043 rst pulsed after 5 bits of 101101 -> all outputs 0; restart, then the 6th bit alone -> no match.
